// File: rtl/cmp_core_sched.sv
// Round-robin scheduler that time-shares one external sum-compare core among N_REQ requesters.
// One request is in flight at a time: IDLE grants, EVAL lets the core settle, RESP holds the result.
module cmp_core_sched #(
  parameter int N_REQ = 4,
  parameter int W     = 3,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*W-1:0] req_c,
  input  logic [N_REQ*W-1:0] req_d,
  output logic [W-1:0]       core_a,
  output logic [W-1:0]       core_b,
  output logic [W-1:0]       core_c,
  output logic [W-1:0]       core_d,
  input  logic               core_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_gt,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy,
  output logic [CNT_W-1:0]   eval_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   id_reg;
  logic [W-1:0]      core_a_reg, core_b_reg, core_c_reg, core_d_reg;
  logic              rsp_valid_reg, rsp_gt_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic [CNT_W-1:0]  eval_cnt_reg;

  logic              grant_any;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   rr_ptr_next;
  logic [N_REQ-1:0]  grant_onehot;
  logic              handshake;
  logic              accept;

  logic [W-1:0] a_arr [N_REQ];
  logic [W-1:0] b_arr [N_REQ];
  logic [W-1:0] c_arr [N_REQ];
  logic [W-1:0] d_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign a_arr[gi]        = req_a[gi*W +: W];
    assign b_arr[gi]        = req_b[gi*W +: W];
    assign c_arr[gi]        = req_c[gi*W +: W];
    assign d_arr[gi]        = req_d[gi*W +: W];
    assign grant_onehot[gi] = grant_any && (grant_idx == ID_W'(gi));
  end

  // Scan from rr_ptr upward, wrapping at N_REQ so non-power-of-2 counts never reach unused indices.
  always_comb begin : p_arb
    logic [ID_W:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = idx[ID_W-1:0];
      end
    end
  end

  assign rr_ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
  assign handshake   = (state_reg == IDLE) && grant_any;
  assign accept      = (state_reg == RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = EVAL;
      EVAL:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Core operands are only loaded on a grant, so core_out is settled for the whole EVAL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      core_a_reg    <= '0;
      core_b_reg    <= '0;
      core_c_reg    <= '0;
      core_d_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_gt_reg    <= 1'b0;
      rsp_id_reg    <= '0;
      eval_cnt_reg  <= '0;
    end else begin
      if (handshake) begin
        core_a_reg <= a_arr[grant_idx];
        core_b_reg <= b_arr[grant_idx];
        core_c_reg <= c_arr[grant_idx];
        core_d_reg <= d_arr[grant_idx];
        id_reg     <= grant_idx;
        rr_ptr_reg <= rr_ptr_next;
      end
      if (state_reg == EVAL) begin
        rsp_gt_reg    <= core_out;
        rsp_id_reg    <= id_reg;
        rsp_valid_reg <= 1'b1;
      end
      if (accept) begin
        rsp_valid_reg <= 1'b0;
        eval_cnt_reg  <= eval_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign req_ready = (state_reg == IDLE) ? grant_onehot : '0;
  assign core_a    = core_a_reg;
  assign core_b    = core_b_reg;
  assign core_c    = core_c_reg;
  assign core_d    = core_d_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_gt    = rsp_gt_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = (state_reg != IDLE);
  assign eval_cnt  = eval_cnt_reg;

endmodule

// File: tb/tb_cmp_core_sched.sv
// Directed bench for cmp_core_sched: a 4-requester instance with a 4-bit counter and a 3-requester instance.
// Both use an exact (a+b)>(c+d) core model driven from the registered operands.
module tb_cmp_core_sched;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-requester instance, CNT_W=4 for the wrap check
  logic [3:0]   req_valid, req_ready;
  logic [11:0]  req_a, req_b, req_c, req_d;
  logic [W-1:0] core_a, core_b, core_c, core_d;
  logic         core_out, rsp_valid, rsp_ready, rsp_gt, busy;
  logic [1:0]   rsp_id;
  logic [3:0]   eval_cnt;

  // 3-requester instance
  logic [2:0]   req_valid3, req_ready3;
  logic [8:0]   req_a3, req_b3, req_c3, req_d3;
  logic [W-1:0] core_a3, core_b3, core_c3, core_d3;
  logic         core_out3, rsp_valid3, rsp_ready3, rsp_gt3, busy3;
  logic [1:0]   rsp_id3;
  logic [15:0]  eval_cnt3;

  assign core_out  = ({1'b0, core_a}  + {1'b0, core_b})  > ({1'b0, core_c}  + {1'b0, core_d});
  assign core_out3 = ({1'b0, core_a3} + {1'b0, core_b3}) > ({1'b0, core_c3} + {1'b0, core_d3});

  cmp_core_sched #(.N_REQ(4), .W(W), .ID_W(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .core_out(core_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_gt(rsp_gt), .rsp_id(rsp_id), .busy(busy), .eval_cnt(eval_cnt)
  );

  cmp_core_sched #(.N_REQ(3), .W(W), .ID_W(2), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_c(req_c3), .req_d(req_d3),
    .core_a(core_a3), .core_b(core_b3), .core_c(core_c3), .core_d(core_d3),
    .core_out(core_out3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_gt(rsp_gt3), .rsp_id(rsp_id3), .busy(busy3), .eval_cnt(eval_cnt3)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_c[i*W +: W] = W'(c);
    req_d[i*W +: W] = W'(d);
  endtask

  // Expected results for the round-robin pattern a=i,b=1,c=2,d=0: (i+1)>2
  logic [3:0] rr_gt_exp;
  logic [3:0] exp_cnt;

  initial begin
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_c = '0; req_d = '0; rsp_ready = 1'b0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_c3 = '0; req_d3 = '0; rsp_ready3 = 1'b0;
    rr_gt_exp = 4'b1100;
    tick(); tick();
    rst = 1'b0;
    tick();

    check_eq("reset busy", busy, 0);
    check_eq("reset rsp_valid", rsp_valid, 0);
    check_eq("reset eval_cnt", eval_cnt, 0);
    check_eq("reset core_a", core_a, 0);
    check_eq("reset req_ready", req_ready, 0);

    // Single request on requester 2: 7+7 > 0+0
    set_ops(2, 7, 7, 0, 0);
    req_valid = 4'b0100;
    #1 check_eq("single req_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check_eq("single busy", busy, 1);
    check_eq("single core_a", core_a, 7);
    check_eq("single req_ready eval", req_ready, 0);
    check_eq("single rsp_valid early", rsp_valid, 0);
    tick();
    check_eq("single rsp_valid", rsp_valid, 1);
    check_eq("single rsp_gt", rsp_gt, 1);
    check_eq("single rsp_id", rsp_id, 2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("single accept rsp_valid", rsp_valid, 0);
    check_eq("single eval_cnt", eval_cnt, 1);
    check_eq("single busy after", busy, 0);

    // Tie on requester 0: 3+2 vs 4+1 -> not greater
    set_ops(0, 3, 2, 4, 1);
    req_valid = 4'b0001;
    #1 check_eq("tie req_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    check_eq("tie rsp_valid", rsp_valid, 1);
    check_eq("tie rsp_gt", rsp_gt, 0);
    check_eq("tie rsp_id", rsp_id, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("tie eval_cnt", eval_cnt, 2);

    // Reset asserted mid-EVAL drops the request
    set_ops(1, 7, 7, 0, 0);
    req_valid = 4'b0010;
    tick();
    check_eq("rst pre busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("rst async busy", busy, 0);
    check_eq("rst async core_a", core_a, 0);
    check_eq("rst async eval_cnt", eval_cnt, 0);
    tick();
    check_eq("rst rsp_valid", rsp_valid, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst rsp_id", rsp_id, 0);
    req_valid = '0;
    rst = 1'b0;
    tick();
    check_eq("rst released req_ready", req_ready, 0);
    check_eq("rst released rsp_valid", rsp_valid, 0);

    // Round-robin: all valid, rsp_ready held high, one result every 3 cycles
    for (int i = 0; i < 4; i++) set_ops(i, i, 1, 2, 0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("rr%0d req_ready", k), req_ready, 4'b0001 << (k % 4));
      tick();
      check_eq($sformatf("rr%0d eval rsp_valid", k), rsp_valid, 0);
      tick();
      check_eq($sformatf("rr%0d rsp_valid", k), rsp_valid, 1);
      check_eq($sformatf("rr%0d rsp_id", k), rsp_id, k % 4);
      check_eq($sformatf("rr%0d rsp_gt", k), rsp_gt, rr_gt_exp[k % 4]);
      tick();
    end
    check_eq("rr eval_cnt", eval_cnt, 5);

    // Backpressure: next grant is requester 1, hold rsp_ready low for 10 cycles
    rsp_ready = 1'b0;
    check_eq("bp req_ready", req_ready, 4'b0010);
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("bp%0d rsp_valid", k), rsp_valid, 1);
      check_eq($sformatf("bp%0d rsp_id", k), rsp_id, 1);
      check_eq($sformatf("bp%0d req_ready", k), req_ready, 0);
      check_eq($sformatf("bp%0d core_a", k), core_a, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("bp released rsp_valid", rsp_valid, 0);
    check_eq("bp eval_cnt", eval_cnt, 6);

    // Counter wrap with a 4-bit counter: 10 more accepts take 6 -> 15 -> 0
    rsp_ready = 1'b1;
    exp_cnt = 4'd6;
    for (int k = 0; k < 10; k++) begin
      tick(); tick(); tick();
      exp_cnt = exp_cnt + 4'd1;
      check_eq($sformatf("wrap%0d eval_cnt", k), eval_cnt, exp_cnt);
    end
    check_eq("wrap final eval_cnt", eval_cnt, 0);
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();

    // Three requesters: pointer sequence 0,1,2,0
    for (int i = 0; i < 3; i++) begin
      req_a3[i*W +: W] = W'(i + 5);
      req_b3[i*W +: W] = W'(0);
      req_c3[i*W +: W] = W'(6);
      req_d3[i*W +: W] = W'(0);
    end
    req_valid3 = 3'b111;
    rsp_ready3 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("n3 %0d req_ready", k), req_ready3, 3'b001 << (k % 3));
      tick();
      tick();
      check_eq($sformatf("n3 %0d rsp_id", k), rsp_id3, k % 3);
      check_eq($sformatf("n3 %0d rsp_gt", k), rsp_gt3, (k % 3) == 2);
      tick();
    end
    check_eq("n3 eval_cnt", eval_cnt3, 4);
    req_valid3 = '0;
    rsp_ready3 = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
